// File: rtl/sync_timing_ctrl_pkg.sv
// Shared constants, metric type and sequencer state encoding for the
// symbol-timing controller.
package sync_timing_ctrl_pkg;

  localparam int FFT_N  = 256;
  localparam int CP_LEN = 64;
  localparam int SYM_P  = FFT_N + CP_LEN;
  localparam int PH_W   = 9;

  typedef logic [15:0] metric_t;

  typedef enum logic [1:0] {
    WARM,
    FILL,
    SEARCH,
    TRACK
  } sync_state_e;

endpackage

// File: rtl/sync_timing_ctrl_peak_tracker.sv
// Running max/argmax over a search window with strict-greater compare,
// so the first occurrence of the peak value wins.
module sync_timing_ctrl_peak_tracker #(
  parameter int VAL_W = 16,
  parameter int IDX_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [VAL_W-1:0] value,
  input  logic [IDX_W-1:0] index,
  output logic [VAL_W-1:0] max_nxt,
  output logic [IDX_W-1:0] arg_nxt
);

  logic [VAL_W-1:0] max_q, max_d;
  logic [IDX_W-1:0] arg_q, arg_d;
  logic             take;

  // max_nxt/arg_nxt include the current sample so the owner can judge the
  // window on its final sample without an extra cycle.
  always_comb begin
    take    = en && (value > max_q);
    max_nxt = take ? value : max_q;
    arg_nxt = take ? index : arg_q;
    max_d   = clr ? '0 : max_nxt;
    arg_d   = clr ? '0 : arg_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      arg_q <= '0;
    end else begin
      max_q <= max_d;
      arg_q <= arg_d;
    end
  end

endmodule

// File: rtl/sync_timing_ctrl.sv
// Symbol-timing sequencer: primes the delay line, searches for the CP
// correlation peak, then tracks FFT-window phase. SYNC_LOCK_STATS_EN adds
// lock-loss and symbol counters.
module sync_timing_ctrl #(
  parameter int FFT_N    = sync_timing_ctrl_pkg::FFT_N,
  parameter int CP_LEN   = sync_timing_ctrl_pkg::CP_LEN,
  parameter int METRIC_W = 16,
  parameter int MISS_MAX = 4,
  parameter int PH_W     = $clog2(FFT_N + CP_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [METRIC_W-1:0] metric,
  input  logic [METRIC_W-1:0] cfg_thresh,
  input  logic                resync,
  output logic                corr_en,
  output logic                sym_start,
  output logic [PH_W-1:0]     phase,
  output logic                locked,
  output logic [PH_W-1:0]     peak_pos
`ifdef SYNC_LOCK_STATS_EN
  ,
  output logic [7:0]          lock_loss_cnt,
  output logic [15:0]         sym_cnt
`endif
);

  import sync_timing_ctrl_pkg::*;

  localparam int              PERIOD     = FFT_N + CP_LEN;
  localparam logic [PH_W-1:0] WARM_LAST  = PH_W'(FFT_N - 1);
  localparam logic [PH_W-1:0] FILL_LAST  = PH_W'(CP_LEN - 1);
  localparam logic [PH_W-1:0] SYM_LAST   = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] LOAD_BASE  = PH_W'(PERIOD - 2);
  localparam logic [3:0]      MISS_LIMIT = 4'(MISS_MAX);

  sync_state_e         state_q, state_d;
  logic [PH_W-1:0]     cnt_q, cnt_d;
  logic [3:0]          miss_q, miss_d;
  logic                corr_en_q, corr_en_d;
  logic                sym_start_q, sym_start_d;
  logic                locked_q, locked_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [PH_W-1:0]     peak_pos_q, peak_pos_d;

  logic                pk_clr, pk_en;
  logic [METRIC_W-1:0] pk_max_nxt;
  logic [PH_W-1:0]     pk_arg_nxt;
  logic [PH_W-1:0]     cur_phase;
  logic [3:0]          miss_inc;
  logic                miss_drop;

  sync_timing_ctrl_peak_tracker #(
    .VAL_W (METRIC_W),
    .IDX_W (PH_W)
  ) u_peak (
    .clk     (clk),
    .rst     (rst),
    .clr     (pk_clr),
    .en      (pk_en),
    .value   (metric),
    .index   (cnt_q),
    .max_nxt (pk_max_nxt),
    .arg_nxt (pk_arg_nxt)
  );

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    miss_d      = miss_q;
    corr_en_d   = corr_en_q;
    sym_start_d = 1'b0;
    locked_d    = locked_q;
    phase_d     = phase_q;
    peak_pos_d  = peak_pos_q;
    pk_clr      = 1'b0;
    pk_en       = 1'b0;
    miss_drop   = 1'b0;
    cur_phase   = (phase_q == SYM_LAST) ? '0 : phase_q + PH_W'(1);
    miss_inc    = miss_q + 4'd1;

    if (resync && (state_q == SEARCH || state_q == TRACK)) begin
      state_d  = SEARCH;
      cnt_d    = '0;
      miss_d   = '0;
      locked_d = 1'b0;
      pk_clr   = 1'b1;
    end else if (in_valid) begin
      unique case (state_q)
        WARM: begin
          if (cnt_q == WARM_LAST) begin
            state_d   = FILL;
            cnt_d     = '0;
            corr_en_d = 1'b1;
          end else begin
            cnt_d = cnt_q + PH_W'(1);
          end
        end
        FILL: begin
          if (cnt_q == FILL_LAST) begin
            state_d = SEARCH;
            cnt_d   = '0;
            pk_clr  = 1'b1;
          end else begin
            cnt_d = cnt_q + PH_W'(1);
          end
        end
        SEARCH: begin
          pk_en = 1'b1;
          if (cnt_q == SYM_LAST) begin
            pk_clr     = 1'b1;
            cnt_d      = '0;
            peak_pos_d = pk_arg_nxt;
            if (pk_max_nxt >= cfg_thresh) begin
              state_d  = TRACK;
              locked_d = 1'b1;
              miss_d   = '0;
              // Peak is the last CP sample, so it must land on phase P-1.
              phase_d  = (pk_arg_nxt == SYM_LAST) ? SYM_LAST : LOAD_BASE - pk_arg_nxt;
            end
          end else begin
            cnt_d = cnt_q + PH_W'(1);
          end
        end
        TRACK: begin
          phase_d     = cur_phase;
          sym_start_d = (cur_phase == '0);
          if (cur_phase == SYM_LAST) begin
            if (metric >= cfg_thresh) begin
              miss_d = '0;
            end else if (miss_inc == MISS_LIMIT) begin
              miss_drop = 1'b1;
              miss_d    = '0;
              state_d   = SEARCH;
              locked_d  = 1'b0;
              cnt_d     = '0;
              pk_clr    = 1'b1;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: state_d = WARM;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WARM;
      cnt_q       <= '0;
      miss_q      <= '0;
      corr_en_q   <= 1'b0;
      sym_start_q <= 1'b0;
      locked_q    <= 1'b0;
      phase_q     <= '0;
      peak_pos_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      corr_en_q   <= corr_en_d;
      sym_start_q <= sym_start_d;
      locked_q    <= locked_d;
      phase_q     <= phase_d;
      peak_pos_q  <= peak_pos_d;
    end
  end

  assign corr_en   = corr_en_q;
  assign sym_start = sym_start_q;
  assign locked    = locked_q;
  assign phase     = phase_q;
  assign peak_pos  = peak_pos_q;

`ifdef SYNC_LOCK_STATS_EN
  logic [7:0]  loss_q, loss_d;
  logic [15:0] sym_cnt_q, sym_cnt_d;

  always_comb begin
    loss_d    = (miss_drop && loss_q != 8'hFF) ? loss_q + 8'd1 : loss_q;
    sym_cnt_d = sym_start_d ? sym_cnt_q + 16'd1 : sym_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_q    <= '0;
      sym_cnt_q <= '0;
    end else begin
      loss_q    <= loss_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  assign lock_loss_cnt = loss_q;
  assign sym_cnt       = sym_cnt_q;
`endif

endmodule
